tvbg_sequencer: RTL and testbench

TVBG_SEQUENCER -- requirements
Module: tvbg_sequencer

---
 rtl/tvbg_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_tvbg_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tvbg_sequencer.sv
// Push-button sequencer that drives a code-playing controller through PASSES table passes.
// Optional run watchdog: define SEQUENCER_WATCHDOG_EN.
module tvbg_sequencer #(
    parameter int DEBOUNCE_BITS = 16,
    parameter int GAP_BITS      = 20,
    parameter int WATCHDOG_BITS = 24,
    parameter int LED_BITS      = 22,
    parameter int PASSES        = 2
) (
    input  logic       clock_in,
    input  logic       reset_in,
    input  logic       button_in,
    input  logic       ctrl_busy_in,
    input  logic       ctrl_fail_in,
    output logic       ctrl_reset_out,
    output logic       ctrl_start_out,
    output logic       led_out,
    output logic       error_out,
    output logic [3:0] pass_count_out
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_GAP   = 3'd4,
        S_ABORT = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    // An out-of-range pass count is clamped into 1..15 so the completion compare stays reachable.
    localparam int unsigned PASS_LIM    = (PASSES < 1) ? 1 : ((PASSES > 15) ? 15 : PASSES);
    localparam logic [4:0]  PASS_TARGET = PASS_LIM[4:0];

    logic                     sync1_q, sync2_q;
    logic                     db_level_q, db_level_d;
    logic [DEBOUNCE_BITS-1:0] db_cnt_q, db_cnt_d;
    logic                     press_q, press_d;

    state_t                   state_q, state_d;
    logic [2:0]               step_q, step_d;
    logic [GAP_BITS-1:0]      gap_q, gap_d;
    logic [LED_BITS-1:0]      led_cnt_q, led_cnt_d;
`ifdef SEQUENCER_WATCHDOG_EN
    logic [WATCHDOG_BITS-1:0] wd_q, wd_d;
`endif
    logic                     ctrl_reset_q, ctrl_reset_d;
    logic                     ctrl_start_q, ctrl_start_d;
    logic                     led_q, led_d;
    logic                     error_q, error_d;
    logic [3:0]               pass_q, pass_d;
    logic [4:0]               pass_inc_s;
    logic                     active_s;

    // Debounce: the level flips only after the synchronised input has disagreed for 2^DEBOUNCE_BITS cycles.
    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        press_d    = 1'b0;
        if (sync2_q != db_level_q) begin
            if (&db_cnt_q) begin
                db_level_d = sync2_q;
                press_d    = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end else begin
            db_cnt_d = '0;
        end
    end

    // Button synchroniser and debounce registers.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_level_q <= 1'b0;
            db_cnt_q   <= '0;
            press_q    <= 1'b0;
        end else begin
            sync1_q    <= button_in;
            sync2_q    <= sync1_q;
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
            press_q    <= press_d;
        end
    end

    // Next-state logic plus the next value of every registered output.
    always_comb begin
        state_d    = state_q;
        step_d     = 3'd0;
        gap_d      = '0;
        pass_d     = pass_q;
        error_d    = error_q;
        pass_inc_s = {1'b0, pass_q} + 5'd1;
`ifdef SEQUENCER_WATCHDOG_EN
        wd_d       = '0;
`endif
        case (state_q)
            S_INIT, S_ABORT: begin
                if (step_q == 3'd1) begin
                    state_d = S_IDLE;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            S_IDLE: begin
                if (press_q) begin
                    pass_d  = 4'd0;
                    error_d = 1'b0;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (press_q) begin
                    state_d = S_ABORT;
                end else if (ctrl_busy_in) begin
                    state_d = S_RUN;
                end else if (step_q == 3'd7) begin
                    state_d = S_ERROR;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            S_RUN: begin
                if (ctrl_fail_in) begin
                    state_d = S_ERROR;
                end else if (press_q) begin
                    state_d = S_ABORT;
                end else if (!ctrl_busy_in) begin
                    pass_d  = (pass_q == 4'd15) ? 4'd15 : pass_inc_s[3:0];
                    state_d = (pass_inc_s == PASS_TARGET) ? S_IDLE : S_GAP;
                end else begin
`ifdef SEQUENCER_WATCHDOG_EN
                    if (&wd_q) begin
                        state_d = S_ERROR;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
`else
                    state_d = S_RUN;
`endif
                end
            end
            S_GAP: begin
                if (press_q) begin
                    state_d = S_ABORT;
                end else if (&gap_q) begin
                    state_d = S_START;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_ERROR: begin
                if (press_q) begin
                    error_d = 1'b0;
                    state_d = S_START;
                end else begin
                    step_d = (step_q == 3'd2) ? 3'd2 : step_q + 3'd1;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase

        if (state_d == S_ERROR) begin
            error_d = 1'b1;
        end else begin
            error_d = error_d;
        end

        ctrl_reset_d = (state_d == S_INIT) || (state_d == S_ABORT) ||
                       ((state_d == S_ERROR) && (step_d < 3'd2));
        ctrl_start_d = (state_d == S_START);

        // The blink phase restarts lit on a fresh run, but carries across GAP -> START.
        active_s  = (state_d == S_START) || (state_d == S_RUN) || (state_d == S_GAP);
        led_cnt_d = '0;
        if (active_s && ((state_q == S_IDLE) || (state_q == S_ERROR))) begin
            led_d = 1'b1;
        end else if (active_s) begin
            led_cnt_d = led_cnt_q + 1'b1;
            led_d     = (&led_cnt_q) ? ~led_q : led_q;
        end else if (state_d == S_ERROR) begin
            led_d = 1'b1;
        end else begin
            led_d = 1'b0;
        end
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q      <= S_INIT;
            step_q       <= 3'd0;
            gap_q        <= '0;
            led_cnt_q    <= '0;
`ifdef SEQUENCER_WATCHDOG_EN
            wd_q         <= '0;
`endif
            ctrl_reset_q <= 1'b1;
            ctrl_start_q <= 1'b0;
            led_q        <= 1'b0;
            error_q      <= 1'b0;
            pass_q       <= 4'd0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            gap_q        <= gap_d;
            led_cnt_q    <= led_cnt_d;
`ifdef SEQUENCER_WATCHDOG_EN
            wd_q         <= wd_d;
`endif
            ctrl_reset_q <= ctrl_reset_d;
            ctrl_start_q <= ctrl_start_d;
            led_q        <= led_d;
            error_q      <= error_d;
            pass_q       <= pass_d;
        end
    end

    assign ctrl_reset_out = ctrl_reset_q;
    assign ctrl_start_out = ctrl_start_q;
    assign led_out        = led_q;
    assign error_out      = error_q;
    assign pass_count_out = pass_q;

endmodule

// File: tb/tb_tvbg_sequencer.sv
// Scoreboard bench for tvbg_sequencer: expected output snapshots (and the cycle spacing
// between them) are queued by the stimulus and consumed by a monitor on every output change.
module tb_tvbg_sequencer;

    localparam int DB_BITS  = 4;
    localparam int GP_BITS  = 6;
    localparam int WD_BITS  = 6;
    localparam int LD_BITS  = 12;
    localparam int NPASS    = 2;
`ifdef SEQUENCER_WATCHDOG_EN
    localparam int RUN_LEN  = 50;
`else
    localparam int RUN_LEN  = 100;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       button;
    logic       busy;
    logic       fail;
    logic       ctrl_reset;
    logic       ctrl_start;
    logic       led;
    logic       error;
    logic [3:0] pass_cnt;

    typedef struct {
        string      name;
        logic [7:0] snap;
        int         delta;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   model_len     = 0;
    int   model_fail_at = -1;

    tvbg_sequencer #(
        .DEBOUNCE_BITS(DB_BITS),
        .GAP_BITS     (GP_BITS),
        .WATCHDOG_BITS(WD_BITS),
        .LED_BITS     (LD_BITS),
        .PASSES       (NPASS)
    ) dut (
        .clock_in      (clk),
        .reset_in      (rst),
        .button_in     (button),
        .ctrl_busy_in  (busy),
        .ctrl_fail_in  (fail),
        .ctrl_reset_out(ctrl_reset),
        .ctrl_start_out(ctrl_start),
        .led_out       (led),
        .error_out     (error),
        .pass_count_out(pass_cnt)
    );

    always #5 clk = ~clk;

    // snapshot = {ctrl_reset, ctrl_start, led, error, pass_count[3:0]}; delta < 0 means "timing not checked"
    task automatic expect_evt(input string name, input logic [7:0] snap, input int delta);
        exp_t e;
        e.name  = name;
        e.snap  = snap;
        e.delta = delta;
        exp_q.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Button held 20 cycles (debounce needs 17), then released 20 cycles so the level settles back to 0.
    task automatic press();
        button = 1'b1;
        wait_cycles(20);
        button = 1'b0;
        wait_cycles(20);
    endtask

    // Controller model: busy rises 2 cycles after start is seen, lasts model_len cycles, optional 1-cycle fail.
    initial begin
        busy = 1'b0;
        fail = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ctrl_start && model_len > 0) begin
                wait_cycles(2);
                busy = 1'b1;
                for (int i = 0; i < model_len; i++) begin
                    fail = (i == model_fail_at);
                    @(posedge clk);
                    #1;
                end
                busy = 1'b0;
                fail = 1'b0;
            end
        end
    end

    // Monitor: every change of the output snapshot pops one expectation.
    initial begin
        logic [7:0] prev;
        logic [7:0] cur;
        int         cyc;
        int         last;
        exp_t       e;
        prev = 8'bxxxxxxxx;
        cyc  = 0;
        last = 0;
        forever begin
            @(negedge clk);
            cyc++;
            cur = {ctrl_reset, ctrl_start, led, error, pass_cnt};
            if (cur !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event at cycle %0d: got=%b required=no change", cyc, cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e.snap) begin
                        failures++;
                        $display("FAIL %s snapshot: got=%b required=%b", e.name, cur, e.snap);
                    end
                    if (e.delta >= 0) begin
                        checks++;
                        if ((cyc - last) != e.delta) begin
                            failures++;
                            $display("FAIL %s spacing: got=%0d cycles required=%0d", e.name, cyc - last, e.delta);
                        end
                    end
                end
                last = cyc;
            end
            if (rst) begin
                last = cyc;
            end
            prev = cur;
        end
    end

    initial begin
        rst    = 1'b1;
        button = 1'b0;

        // Reset state, then exactly two INIT cycles of controller reset after release.
        expect_evt("reset_state", 8'b1_0_0_0_0000, -1);
        expect_evt("init_done",   8'b0_0_0_0_0000, 2);
        repeat (5) @(negedge clk);
        #1 rst = 1'b0;
        wait_cycles(10);

        // A 10-cycle glitch must not register as a press.
        button = 1'b1;
        wait_cycles(10);
        button = 1'b0;
        wait_cycles(30);

        // Two full passes separated by a 2^GAP_BITS gap, back to idle with pass_count=2.
        model_len     = RUN_LEN;
        model_fail_at = -1;
        expect_evt("p1_start", 8'b0_1_1_0_0000, -1);
        expect_evt("p1_busy",  8'b0_0_1_0_0000, 3);
        expect_evt("p1_done",  8'b0_0_1_0_0001, RUN_LEN);
        expect_evt("p2_start", 8'b0_1_1_0_0001, 64);
        expect_evt("p2_busy",  8'b0_0_1_0_0001, 3);
        expect_evt("p2_done",  8'b0_0_0_0_0010, RUN_LEN);
        press();
        wait_cycles(2 * RUN_LEN + 94);

        // Controller never answers: start held 8 cycles, then error with a 2-cycle reset pulse.
        model_len = 0;
        expect_evt("nb_start",   8'b0_1_1_0_0000, -1);
        expect_evt("nb_error",   8'b1_0_1_1_0000, 8);
        expect_evt("nb_err_rst", 8'b0_0_1_1_0000, 2);
        press();
        wait_cycles(20);

        // Press from error restarts directly; fail during the run goes back to error.
        model_len     = RUN_LEN;
        model_fail_at = 20;
        expect_evt("f_start",   8'b0_1_1_0_0000, -1);
        expect_evt("f_busy",    8'b0_0_1_0_0000, 3);
        expect_evt("f_error",   8'b1_0_1_1_0000, 20);
        expect_evt("f_err_rst", 8'b0_0_1_1_0000, 2);
        press();
        wait_cycles(RUN_LEN + 20);

        // Press during RUN aborts with a 2-cycle controller reset.
        model_fail_at = -1;
        expect_evt("ar_start", 8'b0_1_1_0_0000, -1);
        expect_evt("ar_busy",  8'b0_0_1_0_0000, 3);
        expect_evt("ar_abort", 8'b1_0_0_0_0000, 37);
        expect_evt("ar_idle",  8'b0_0_0_0_0000, 2);
        press();
        press();
        wait_cycles(RUN_LEN + 20);

        // Press during GAP aborts; pass_count keeps its value.
        expect_evt("ag_start", 8'b0_1_1_0_0000, -1);
        expect_evt("ag_busy",  8'b0_0_1_0_0000, 3);
        expect_evt("ag_gap",   8'b0_0_1_0_0001, RUN_LEN);
        expect_evt("ag_abort", 8'b1_0_0_0_0001, 27);
        expect_evt("ag_idle",  8'b0_0_0_0_0001, 2);
        press();
        wait_cycles(RUN_LEN - 10);
        press();
        wait_cycles(40);

        // Reset asserted during the second pass clears everything; INIT reset still lasts 2 cycles.
        expect_evt("mr_start",  8'b0_1_1_0_0000, -1);
        expect_evt("mr_busy",   8'b0_0_1_0_0000, 3);
        expect_evt("mr_gap",    8'b0_0_1_0_0001, RUN_LEN);
        expect_evt("mr_start2", 8'b0_1_1_0_0001, 64);
        expect_evt("mr_busy2",  8'b0_0_1_0_0001, 3);
        expect_evt("mr_reset",  8'b1_0_0_0_0000, -1);
        expect_evt("mr_init",   8'b0_0_0_0_0000, 2);
        press();
        wait_cycles(RUN_LEN + 75);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        wait_cycles(RUN_LEN + 30);

`ifdef SEQUENCER_WATCHDOG_EN
        // Busy held past 2^WATCHDOG_BITS cycles trips the watchdog at cycle 64 of the run.
        model_len = 100;
        expect_evt("wd_start",   8'b0_1_1_0_0000, -1);
        expect_evt("wd_busy",    8'b0_0_1_0_0000, 3);
        expect_evt("wd_error",   8'b1_0_1_1_0000, 64);
        expect_evt("wd_err_rst", 8'b0_0_1_1_0000, 2);
        press();
        wait_cycles(150);
`endif

        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_events: got=%0d outstanding required=0 (next %s)", exp_q.size(), exp_q[0].name);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
